// File: rtl/crypto_issue_ctrl.sv
// Issue sequencer for the shared multi-cycle scalar-crypto unit: latches a decoded op,
// starts the unit, stalls the pipeline until done/timeout, then writes back one register.
module crypto_issue_ctrl #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned OP_W    = 20,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_valid,
   input  logic [OP_W-1:0] issue_op,
   input  logic [XLEN-1:0] issue_rs1,
   input  logic [XLEN-1:0] issue_rs2,
   input  logic [4:0]      issue_rd,
   input  logic            flush,
   output logic            stall,
   output logic            illegal_o,
   output logic            cu_start,
   output logic [OP_W-1:0] cu_op,
   output logic [XLEN-1:0] cu_a,
   output logic [XLEN-1:0] cu_b,
   input  logic            cu_done,
   input  logic [XLEN-1:0] cu_result,
   output logic            wb_we,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            err_o
);

   localparam int unsigned CNT_W  = $clog2(TIMEOUT);
   localparam int unsigned HOT_W  = 18;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WB,
      S_DRAIN
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [4:0]       dest_rd;

   logic [HOT_W-1:0] hot;
   logic             legal;
   logic             accept;
   logic             at_last;

   // Exactly one of the 18 op bits must be set; byte-select bits are not part of the check.
   always_comb begin
      hot     = issue_op[HOT_W-1:0];
      legal   = (hot != '0) && ((hot & (hot - HOT_W'(1))) == '0);
      accept  = issue_valid & legal & ~flush;
      at_last = (count == CNT_LAST);
   end

   // Stall is combinational so decode is held in the same cycle the op is seen.
   always_comb begin
      stall     = 1'b0;
      illegal_o = 1'b0;
      if (rst) begin
         case (state)
            S_IDLE: begin
               stall     = accept;
               illegal_o = issue_valid & ~legal;
            end
            S_ISSUE, S_WAIT: stall = 1'b1;
            S_DRAIN:         stall = issue_valid;
            default:         stall = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         count    <= '0;
         dest_rd  <= '0;
         cu_start <= 1'b0;
         cu_op    <= '0;
         cu_a     <= '0;
         cu_b     <= '0;
         wb_we    <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
         err_o    <= 1'b0;
      end else begin
         cu_start <= 1'b0;
         wb_we    <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
         err_o    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cu_op    <= issue_op;
                  cu_a     <= issue_rs1;
                  cu_b     <= issue_rs2;
                  dest_rd  <= issue_rd;
                  cu_start <= 1'b1;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               count <= '0;
               state <= flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
               // Flush wins: the unit cannot be aborted, so wait it out in DRAIN.
               if (flush) begin
                  if (!at_last) count <= count + CNT_W'(1);
                  state <= S_DRAIN;
               end else if (cu_done) begin
                  wb_we   <= (dest_rd != 5'd0);
                  wb_rd   <= dest_rd;
                  wb_data <= cu_result;
                  state   <= S_WB;
               end else if (at_last) begin
                  wb_we   <= (dest_rd != 5'd0);
                  wb_rd   <= dest_rd;
                  wb_data <= '0;
                  err_o   <= 1'b1;
                  state   <= S_WB;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            S_WB: begin
               state <= S_IDLE;
            end
            S_DRAIN: begin
               if (cu_done || at_last) begin
                  state <= S_IDLE;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_crypto_issue_ctrl.sv
// Bench for crypto_issue_ctrl: IDLE decode table, cycle-scripted sequences,
// and a writeback scoreboard fed at issue time and drained by a monitor.
module tb_crypto_issue_ctrl;

   localparam int unsigned XLEN = 32;
   localparam int unsigned OP_W = 20;
   localparam int unsigned TO   = 8;
   localparam logic [19:0] OP_AES = 20'h00800;

   logic            clk = 1'b0;
   logic            rst;
   logic            issue_valid;
   logic [OP_W-1:0] issue_op;
   logic [XLEN-1:0] issue_rs1;
   logic [XLEN-1:0] issue_rs2;
   logic [4:0]      issue_rd;
   logic            flush;
   logic            stall;
   logic            illegal_o;
   logic            cu_start;
   logic [OP_W-1:0] cu_op;
   logic [XLEN-1:0] cu_a;
   logic [XLEN-1:0] cu_b;
   logic            cu_done;
   logic [XLEN-1:0] cu_result;
   logic            wb_we;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            err_o;

   crypto_issue_ctrl #(.XLEN(XLEN), .OP_W(OP_W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_op(issue_op),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd), .flush(flush),
      .stall(stall), .illegal_o(illegal_o), .cu_start(cu_start), .cu_op(cu_op),
      .cu_a(cu_a), .cu_b(cu_b), .cu_done(cu_done), .cu_result(cu_result),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        err;
   } wb_t;

   wb_t sb_q[$];
   wb_t mon_got;
   wb_t mon_exp;

   typedef struct {
      logic        valid;
      logic        fl;
      logic [19:0] op;
      logic        exp_stall;
      logic        exp_illegal;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic fl, input logic [19:0] op,
                        input logic [4:0] rd, input logic [31:0] rs1,
                        input logic dn, input logic [31:0] res);
      issue_valid = v;
      flush       = fl;
      issue_op    = op;
      issue_rd    = rd;
      issue_rs1   = rs1;
      issue_rs2   = 32'h0;
      cu_done     = dn;
      cu_result   = res;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, 20'h0, 5'd0, 32'h0, 1'b0, 32'h0);
         next_cycle();
      end
   endtask

   // Every writeback or error pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst === 1'b1 && (wb_we === 1'b1 || err_o === 1'b1)) begin
         mon_got = {wb_we, wb_rd, wb_data, err_o};
         if (sb_q.size() == 0) begin
            check("unexpected_wb", 64'(mon_got), 64'(0));
         end else begin
            mon_exp = sb_q.pop_front();
            check("wb", 64'(mon_got), 64'(mon_exp));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 1'b0, OP_AES,   1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 20'h00003, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 1'b1, OP_AES,   1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 20'h00000, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 1'b0, OP_AES,   1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 20'hC0001, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 20'h20000, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 20'h30000, 1'b0, 1'b1};
      vecs[8] = '{1'b1, 1'b0, 20'hC0000, 1'b0, 1'b1};

      // Reset held with a legal op presented
      rst = 1'b0;
      drive(1'b1, 1'b0, OP_AES, 5'd5, 32'h1, 1'b0, 32'h0);
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("rst_stall_%0d", c), 64'(stall), 64'(0));
         check($sformatf("rst_start_%0d", c), 64'(cu_start), 64'(0));
         check($sformatf("rst_we_%0d", c), 64'(wb_we), 64'(0));
         check($sformatf("rst_err_%0d", c), 64'(err_o), 64'(0));
         next_cycle();
      end
      drive(1'b0, 1'b0, 20'h0, 5'd0, 32'h0, 1'b0, 32'h0);
      rst = 1'b1;
      idle(2);

      // IDLE decode table, combinational only (no clock edge between entries)
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].valid, vecs[i].fl, vecs[i].op, 5'd1, 32'h0, 1'b0, 32'h0);
         #1;
         check($sformatf("tbl_stall_%0d", i), 64'(stall), 64'(vecs[i].exp_stall));
         check($sformatf("tbl_illegal_%0d", i), 64'(illegal_o), 64'(vecs[i].exp_illegal));
      end
      idle(1);

      // Illegal op held across edges: nothing issues
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 1'b0, 20'h00003, 5'd5, 32'h0, 1'b0, 32'h0);
         @(negedge clk);
         check($sformatf("ill_start_%0d", c), 64'(cu_start), 64'(0));
         check($sformatf("ill_stall_%0d", c), 64'(stall), 64'(0));
         check($sformatf("ill_flag_%0d", c), 64'(illegal_o), 64'(1));
         next_cycle();
      end
      idle(2);

      // Normal: done 4 cycles after start, writeback at cycle 6
      for (int c = 0; c <= 8; c++) begin
         drive(c <= 6, 1'b0, OP_AES, 5'd5, 32'h12345678, c == 5, (c == 5) ? 32'hDEADBEEF : 32'h0);
         if (c == 0) sb_q.push_back({1'b1, 5'd5, 32'hDEADBEEF, 1'b0});
         @(negedge clk);
         check($sformatf("norm_stall_%0d", c), 64'(stall), 64'(c <= 5));
         check($sformatf("norm_start_%0d", c), 64'(cu_start), 64'(c == 1));
         if (c == 3) begin
            check("norm_cu_a", 64'(cu_a), 64'h12345678);
            check("norm_cu_b", 64'(cu_b), 64'h0);
            check("norm_cu_op", 64'(cu_op), 64'(OP_AES));
         end
         if (c == 6) check("norm_we", 64'(wb_we), 64'(1));
         next_cycle();
      end
      idle(2);

      // rd = 0: WB cycle happens, no write
      for (int c = 0; c <= 8; c++) begin
         drive(c <= 6, 1'b0, OP_AES, 5'd0, 32'h5, c == 5, (c == 5) ? 32'h600DF00D : 32'h0);
         @(negedge clk);
         check($sformatf("rd0_stall_%0d", c), 64'(stall), 64'(c <= 5));
         if (c == 6) check("rd0_we", 64'(wb_we), 64'(0));
         next_cycle();
      end
      idle(2);

      // Flush in WAIT, drain until done, then the next instruction issues at cycle 9
      for (int c = 0; c <= 13; c++) begin
         drive(c <= 12, c == 3, OP_AES, (c <= 3) ? 5'd5 : 5'd7,
               (c <= 3) ? 32'h1 : 32'h0BAD,
               (c == 7) || (c == 11), (c == 7) ? 32'h11111111 : 32'hCAFEF00D);
         if (c == 8) sb_q.push_back({1'b1, 5'd7, 32'hCAFEF00D, 1'b0});
         @(negedge clk);
         check($sformatf("fl_stall_%0d", c), 64'(stall), 64'(c <= 11));
         check($sformatf("fl_start_%0d", c), 64'(cu_start), 64'((c == 1) || (c == 9)));
         if (c == 10) check("fl_cu_a", 64'(cu_a), 64'h0BAD);
         next_cycle();
      end
      idle(2);

      // Timeout: no done ever, error writeback of zero at cycle 10
      for (int c = 0; c <= 11; c++) begin
         drive(c <= 10, 1'b0, OP_AES, 5'd5, 32'h9, 1'b0, 32'h0);
         if (c == 0) sb_q.push_back({1'b1, 5'd5, 32'h0, 1'b1});
         @(negedge clk);
         check($sformatf("to_stall_%0d", c), 64'(stall), 64'(c <= 9));
         if (c == 10) begin
            check("to_err", 64'(err_o), 64'(1));
            check("to_we", 64'(wb_we), 64'(1));
         end
         if (c == 11) check("to_err_clear", 64'(err_o), 64'(0));
         next_cycle();
      end
      idle(2);

      // Reset during WAIT: late done must not write back
      for (int c = 0; c <= 6; c++) begin
         drive(c <= 2, 1'b0, OP_AES, 5'd9, 32'h77, c == 4, 32'h44444444);
         rst = (c == 3) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (c >= 3) check($sformatf("mid_stall_%0d", c), 64'(stall), 64'(0));
         if (c == 4) begin
            check("mid_cu_op", 64'(cu_op), 64'(0));
            check("mid_start", 64'(cu_start), 64'(0));
         end
         next_cycle();
      end
      rst = 1'b1;
      idle(3);

      check("sb_empty", 64'(sb_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
